flag_unit: RTL and testbench

Architectural condition-flag producer for the CPU datapath. It computes the 4-bit flag vector that the jump-condition logic consumes, from ALU operands, through a one-stage pipeline. It holds the flags in an architectural register, supports direct loads, and provides an optional LIFO shadow stack for interrupt save and restore. Flag encoding is fixed: bit 0 = S (sign), bit 1 = V (signed overflow), bit 2 = Z (zero), bit 3 = C (carry on ADD, borrow on SUB).

---
 rtl/flag_unit.sv | 166 ++++++++++++++++
 tb/tb_flag_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/flag_unit.sv
// Condition-flag producer: one-stage pipeline from ALU operands to the {C,Z,V,S} register,
// direct loads, and an optional LIFO shadow stack compiled in when FLAG_STACK_EN is defined.
module flag_unit #(
    parameter int WIDTH       = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flags_we,
    input  logic [3:0]       flags_wdata,
    input  logic             push,
    input  logic             pop,
    output logic [3:0]       flags,
    output logic             flags_valid,
    output logic             err
);
    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_AND  = 2'd2;
    localparam logic [1:0] OP_TEST = 2'd3;

    logic [1:0]       s1_op_reg;
    logic [WIDTH-1:0] s1_a_reg;
    logic [WIDTH-1:0] s1_b_reg;
    logic             s1_valid_reg;
    logic [3:0]       flags_reg;
    logic             err_reg;

    logic             accept;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             c_flag;
    logic             v_flag;
    logic [3:0]       wb_flags;

    logic             eff_push;
    logic             eff_pop;
    logic             stack_full;
    logic             stack_empty;
    logic [3:0]       stack_top;
    logic             cmd_err;
    logic             do_load;
    logic             do_push;
    logic             do_pop;

    assign in_ready    = ~(flags_we | push | pop);
    assign accept      = in_valid & in_ready;
    assign flags       = flags_reg;
    assign flags_valid = ~s1_valid_reg;
    assign err         = err_reg;

    always_comb begin
        sum    = {1'b0, s1_a_reg} + {1'b0, s1_b_reg};
        res    = s1_a_reg;
        c_flag = 1'b0;
        v_flag = 1'b0;
        case (s1_op_reg)
            OP_ADD: begin
                res    = sum[WIDTH-1:0];
                c_flag = sum[WIDTH];
                v_flag = (s1_a_reg[WIDTH-1] == s1_b_reg[WIDTH-1]) &&
                         (res[WIDTH-1] != s1_a_reg[WIDTH-1]);
            end
            OP_SUB: begin
                res    = s1_a_reg - s1_b_reg;
                c_flag = s1_a_reg < s1_b_reg;
                v_flag = (s1_a_reg[WIDTH-1] != s1_b_reg[WIDTH-1]) &&
                         (res[WIDTH-1] != s1_a_reg[WIDTH-1]);
            end
            OP_AND:  res = s1_a_reg & s1_b_reg;
            OP_TEST: res = s1_a_reg;
            default: res = s1_a_reg;
        endcase
        wb_flags = {c_flag, (res == '0), v_flag, res[WIDTH-1]};
    end

`ifdef FLAG_STACK_EN
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);

    logic [3:0]      stack_mem [STACK_DEPTH];
    logic [SP_W-1:0] sp_reg;

    assign eff_push    = push;
    assign eff_pop     = pop;
    assign stack_full  = (sp_reg == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp_reg == '0);
    // Read is combinational so a pop restores flags at the edge ending its own cycle.
    assign stack_top   = stack_mem[IDX_W'(sp_reg - 1'b1)];

    always_ff @(posedge clk) begin
        if (do_push) begin
            stack_mem[IDX_W'(sp_reg)] <= flags_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_reg <= '0;
        end else if (do_push) begin
            sp_reg <= sp_reg + 1'b1;
        end else if (do_pop) begin
            sp_reg <= sp_reg - 1'b1;
        end
    end
`else
    assign eff_push    = 1'b0;
    assign eff_pop     = 1'b0;
    assign stack_full  = 1'b0;
    assign stack_empty = 1'b1;
    assign stack_top   = 4'b0000;
`endif

    // Sideband decode; any illegal combination is dropped whole, including push+load at full.
    always_comb begin
        cmd_err = 1'b0;
        do_load = 1'b0;
        do_push = 1'b0;
        do_pop  = 1'b0;
        if (s1_valid_reg) begin
            cmd_err = flags_we | eff_push | eff_pop;
        end else if ((eff_push & eff_pop) | (eff_pop & flags_we)) begin
            cmd_err = 1'b1;
        end else if ((eff_push & stack_full) | (eff_pop & stack_empty)) begin
            cmd_err = 1'b1;
        end else begin
            do_load = flags_we;
            do_push = eff_push;
            do_pop  = eff_pop;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_op_reg <= op;
            s1_a_reg  <= a;
            s1_b_reg  <= b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            flags_reg    <= 4'b0000;
            err_reg      <= 1'b0;
        end else begin
            s1_valid_reg <= accept;
            if (s1_valid_reg) begin
                flags_reg <= wb_flags;
            end else if (do_pop) begin
                flags_reg <= stack_top;
            end else if (do_load) begin
                flags_reg <= flags_wdata;
            end
            if (cmd_err) begin
                err_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_flag_unit.sv
// Scoreboard bench for flag_unit: stimulus queues expected {flags,flags_valid,err} per cycle,
// a negedge monitor pops and compares. Stack cases run only when FLAG_STACK_EN is defined.
module tb_flag_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] op = 2'd0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       flags_we = 1'b0;
    logic [3:0] flags_wdata = 4'h0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [3:0] flags;
    logic       flags_valid;
    logic       err;

    flag_unit #(.WIDTH(8), .STACK_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .flags_we(flags_we), .flags_wdata(flags_wdata),
        .push(push), .pop(pop), .flags(flags), .flags_valid(flags_valid), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        string      name;
        logic [3:0] fl;
        logic       fv;
        logic       er;
    } exp_t;

    exp_t sbq[$];
    int errors = 0;
    int checks = 0;

    function automatic void chk(string name, logic [15:0] act, logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endfunction

    task automatic sb_push(int dc, string nm, logic [3:0] fl, logic fv, logic er);
        exp_t e;
        e.at = cyc + dc;
        e.name = nm;
        e.fl = fl;
        e.fv = fv;
        e.er = er;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sbq.size() > 0 && sbq[0].at <= cyc) begin
            e = sbq.pop_front();
            chk(e.name, 16'({flags, flags_valid, err}), 16'({e.fl, e.fv, e.er}));
        end
    end

    task automatic drive(logic iv, logic [1:0] o, logic [7:0] av, logic [7:0] bv,
                         logic we, logic [3:0] wd, logic pu, logic po);
        in_valid = iv; op = o; a = av; b = bv;
        flags_we = we; flags_wdata = wd; push = pu; pop = po;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        drive(0, 2'd0, 8'h00, 8'h00, 0, 4'h0, 0, 0);
        repeat (n) step();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 16'({flags, flags_valid, err, in_ready}), 16'({4'b0000, 1'b1, 1'b0, 1'b1}));
        rst_n = 1'b1;
        step();

        // ADD 0x7F+0x01: S and V set, visible two cycles after acceptance
        drive(1, 2'd0, 8'h7F, 8'h01, 0, 4'h0, 0, 0);
        sb_push(1, "add_pending", 4'b0000, 0, 0);
        sb_push(2, "add_7f_01", 4'b0011, 1, 0);
        step();
        idle(3);

        // Back-to-back SUBs
        drive(1, 2'd1, 8'h05, 8'h05, 0, 4'h0, 0, 0);
        sb_push(1, "sub_pending", 4'b0011, 0, 0);
        sb_push(2, "sub_5_5", 4'b0100, 0, 0);
        sb_push(3, "sub_3_5", 4'b1001, 1, 0);
        step();
        drive(1, 2'd1, 8'h03, 8'h05, 0, 4'h0, 0, 0);
        step();
        idle(3);

        // Load C|Z, then AND must clear C
        drive(0, 2'd0, 8'h00, 8'h00, 1, 4'b1100, 0, 0);
        sb_push(1, "load_1100", 4'b1100, 1, 0);
        step();
        idle(1);
        drive(1, 2'd2, 8'hF0, 8'h0F, 0, 4'h0, 0, 0);
        sb_push(2, "and_f0_0f", 4'b0100, 1, 0);
        step();
        idle(3);

        // Load C|V, then TEST 0x80 must clear both
        drive(0, 2'd0, 8'h00, 8'h00, 1, 4'b1010, 0, 0);
        sb_push(1, "load_1010", 4'b1010, 1, 0);
        step();
        idle(1);
        drive(1, 2'd3, 8'h80, 8'h33, 0, 4'h0, 0, 0);
        sb_push(2, "test_80", 4'b0001, 1, 0);
        step();
        idle(3);

        // Request offered alongside a load is not accepted
        drive(1, 2'd0, 8'h7F, 8'h01, 1, 4'b0110, 0, 0);
        #1;
        chk("ready_low_we", 16'(in_ready), 16'(1'b0));
        sb_push(1, "load_wins", 4'b0110, 1, 0);
        sb_push(2, "req_dropped", 4'b0110, 1, 0);
        step();
        idle(3);

`ifndef FLAG_STACK_EN
        // No stack: push/pop block requests but do nothing else
        drive(0, 2'd0, 8'h00, 8'h00, 0, 4'h0, 1, 0);
        #1;
        chk("ready_low_push", 16'(in_ready), 16'(1'b0));
        sb_push(1, "push_ignored", 4'b0110, 1, 0);
        step();
        drive(0, 2'd0, 8'h00, 8'h00, 0, 4'h0, 0, 1);
        sb_push(1, "pop_ignored", 4'b0110, 1, 0);
        step();
        idle(2);
`endif

        // Load while a writeback is pending: ignored, err set
        drive(1, 2'd0, 8'h7F, 8'h01, 0, 4'h0, 0, 0);
        step();
        drive(0, 2'd0, 8'h00, 8'h00, 1, 4'b1111, 0, 0);
        sb_push(0, "busy_pending", 4'b0110, 0, 0);
        sb_push(1, "busy_load_err", 4'b0011, 1, 1);
        step();
        idle(3);

        // Async reset while s1 holds a SUB 3-5
        drive(1, 2'd1, 8'h03, 8'h05, 0, 4'h0, 0, 0);
        step();
        idle(0);
        rst_n = 1'b0;
        #1;
        chk("rst_async", 16'({flags, flags_valid, err}), 16'({4'b0000, 1'b1, 1'b0}));
        step();
        rst_n = 1'b1;
        sb_push(0, "no_wb_0", 4'b0000, 1, 0);
        sb_push(1, "no_wb_1", 4'b0000, 1, 0);
        step();
        idle(2);

`ifdef FLAG_STACK_EN
        // Fill the 4-deep stack with 0001,0010,0100,1000
        drive(0, 2'd0, 8'h00, 8'h00, 1, 4'b0001, 0, 0);
        sb_push(1, "ld_0001", 4'b0001, 1, 0);
        step();
        drive(0, 2'd0, 8'h00, 8'h00, 1, 4'b0010, 1, 0);
        sb_push(1, "pushld_0010", 4'b0010, 1, 0);
        step();
        drive(0, 2'd0, 8'h00, 8'h00, 1, 4'b0100, 1, 0);
        sb_push(1, "pushld_0100", 4'b0100, 1, 0);
        step();
        drive(0, 2'd0, 8'h00, 8'h00, 1, 4'b1000, 1, 0);
        sb_push(1, "pushld_1000", 4'b1000, 1, 0);
        step();
        drive(0, 2'd0, 8'h00, 8'h00, 0, 4'h0, 1, 0);
        sb_push(1, "push_4th", 4'b1000, 1, 0);
        step();
        drive(0, 2'd0, 8'h00, 8'h00, 1, 4'b1111, 1, 0);
        sb_push(1, "push_full", 4'b1000, 1, 1);
        step();
        drive(0, 2'd0, 8'h00, 8'h00, 0, 4'h0, 0, 1);
        sb_push(1, "pop_1", 4'b1000, 1, 1);
        sb_push(2, "pop_2", 4'b0100, 1, 1);
        sb_push(3, "pop_3", 4'b0010, 1, 1);
        sb_push(4, "pop_4", 4'b0001, 1, 1);
        sb_push(5, "pop_empty", 4'b0001, 1, 1);
        repeat (5) step();
        idle(2);
`endif

        for (int i = 0; i < 20 && sbq.size() > 0; i++) step();
        if (sbq.size() > 0) chk("sb_drain", 16'(sbq.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim time exceeded, errors=%0d", errors);
        $fatal(1, "timeout");
    end
endmodule
